// File: rtl/bird_bus_pkg.sv
// ============================================================================
// Module : bird_bus_pkg
// Brief  : Shared types and default address map for the bird bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bird_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    RG_MEM    = 3'd0,
    RG_KPDATA = 3'd1,
    RG_KPSTAT = 3'd2,
    RG_SEG    = 3'd3,
    RG_NONE   = 3'd4
  } region_e;

  localparam logic [11:0] C_MEM_END    = 12'h1FF;
  localparam logic [11:0] C_KEYPAD     = 12'h900;
  localparam logic [11:0] C_SEVENSEG   = 12'hB00;
  localparam logic [15:0] C_DEFAULT_RD = 16'hF345;

endpackage

`default_nettype wire

// File: rtl/bird_addr_decode.sv
// ============================================================================
// Module : bird_addr_decode
// Brief  : Combinational address decode to region, error flag and write commit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_addr_decode
  import bird_bus_pkg::*;
#(
  parameter logic [11:0] MEM_END  = C_MEM_END,
  parameter logic [11:0] KEYPAD   = C_KEYPAD,
  parameter logic [11:0] SEVENSEG = C_SEVENSEG
) (
  input  logic [11:0] addr_i,
  input  logic        we_i,
  output region_e     region_o,
  output logic        rerr_o,
  output logic        wr_commit_o
);

  always_comb begin
    region_o = RG_NONE;
    if (addr_i <= MEM_END)                 region_o = RG_MEM;
    else if (addr_i == KEYPAD)             region_o = RG_KPDATA;
    else if (addr_i == KEYPAD + 12'd1)     region_o = RG_KPSTAT;
    else if (addr_i == SEVENSEG)           region_o = RG_SEG;
  end

  assign rerr_o = (region_o == RG_NONE);
  // Only memory and the segment register accept writes; all others drop them.
  assign wr_commit_o = we_i && ((region_o == RG_MEM) || (region_o == RG_SEG));

endmodule

`default_nettype wire

// File: rtl/bird_bus_arbiter.sv
// ============================================================================
// Module : bird_bus_arbiter
// Brief  : Two-master round-robin arbiter and address decoder for the bird bus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_bus_arbiter
  import bird_bus_pkg::*;
#(
  parameter logic [11:0] MEM_END    = C_MEM_END,
  parameter logic [11:0] KEYPAD     = C_KEYPAD,
  parameter logic [11:0] SEVENSEG   = C_SEVENSEG,
  parameter logic [15:0] DEFAULT_RD = C_DEFAULT_RD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [11:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  output logic        m0_rerr,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [11:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  output logic        m1_rerr,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        kp_ack,
  output logic        kp_statusordata,
  input  logic [15:0] kp_keyout,
  output logic [15:0] seg_data
);

  state_e      state_q, state_d;
  region_e     region_q, region_d;
  logic        last_q, last_d;
  logic        winner_q, winner_d;
  logic        we_q, we_d;
  logic        commit_q, commit_d;
  logic        rerr_q, rerr_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] seg_q, seg_d;

  logic        any_req, pick, sel_we, dec_rerr, dec_commit;
  logic [11:0] sel_addr;
  region_e     dec_region;

  assign any_req  = m0_req | m1_req;
  // pick = 1 selects m1; on a tie the master that was not granted last wins.
  assign pick     = (m0_req && m1_req) ? ~last_q : m1_req;
  assign sel_addr = pick ? m1_addr : m0_addr;
  assign sel_we   = pick ? m1_we : m0_we;

  bird_addr_decode #(
    .MEM_END  (MEM_END),
    .KEYPAD   (KEYPAD),
    .SEVENSEG (SEVENSEG)
  ) u_decode (
    .addr_i      (sel_addr),
    .we_i        (sel_we),
    .region_o    (dec_region),
    .rerr_o      (dec_rerr),
    .wr_commit_o (dec_commit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      region_q <= RG_NONE;
      last_q   <= 1'b1;
      winner_q <= 1'b0;
      we_q     <= 1'b0;
      commit_q <= 1'b0;
      rerr_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      seg_q    <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      commit_q <= commit_d;
      rerr_q   <= rerr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      seg_q    <= seg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    last_d   = last_q;
    winner_d = winner_q;
    we_d     = we_q;
    commit_d = commit_q;
    rerr_d   = rerr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    seg_d    = seg_q;

    case (state_q)
      ST_ACCESS: begin
        state_d = ST_RESP;
        rdata_d = '0;
        if (!we_q) begin
          case (region_q)
            RG_KPDATA, RG_KPSTAT: rdata_d = kp_keyout;
            RG_SEG:               rdata_d = seg_q;
            RG_NONE:              rdata_d = DEFAULT_RD;
            default:              rdata_d = '0;
          endcase
        end
        if (commit_q && (region_q == RG_SEG)) seg_d = wdata_q;
      end
      default: begin
        // IDLE and RESP both arbitrate; RESP falls back to IDLE when quiet.
        state_d = ST_IDLE;
        if (any_req) begin
          state_d  = ST_ACCESS;
          winner_d = pick;
          last_d   = pick;
          region_d = dec_region;
          rerr_d   = dec_rerr;
          commit_d = dec_commit;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = pick ? m1_wdata : m0_wdata;
        end
      end
    endcase
  end

  logic        in_access, in_resp;
  logic [15:0] resp_data;

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);
  assign resp_data = (region_q == RG_MEM) ? (we_q ? 16'h0000 : mem_rdata) : rdata_q;

  assign m0_gnt    = in_access && !winner_q;
  assign m1_gnt    = in_access &&  winner_q;
  assign m0_rvalid = in_resp && !winner_q;
  assign m1_rvalid = in_resp &&  winner_q;
  assign m0_rdata  = m0_rvalid ? resp_data : 16'h0000;
  assign m1_rdata  = m1_rvalid ? resp_data : 16'h0000;
  assign m0_rerr   = m0_rvalid && rerr_q;
  assign m1_rerr   = m1_rvalid && rerr_q;

  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_we          = in_access && commit_q && (region_q == RG_MEM);
  assign kp_ack          = in_access && !we_q && (region_q == RG_KPDATA);
  assign kp_statusordata = in_access && !we_q && (region_q == RG_KPSTAT);
  assign seg_data        = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_bird_bus_arbiter.sv
// ============================================================================
// Module : tb_bird_bus_arbiter
// Brief  : Directed self-checking bench for bird_bus_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bird_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [11:0] m0_addr = '0, m1_addr = '0;
  logic [15:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
  logic [15:0] m0_rdata, m1_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        kp_ack, kp_statusordata;
  logic [15:0] kp_keyout = '0;
  logic [15:0] seg_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [4096];

  always #5 clk = ~clk;

  // Synchronous-read memory model attached to the memory port.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  bird_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .kp_ack(kp_ack), .kp_statusordata(kp_statusordata), .kp_keyout(kp_keyout),
    .seg_data(seg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [11:0] a, input logic [15:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [11:0] a, input logic [15:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h005] = 16'h1234;
    mem[12'h010] = 16'hA010;
    mem[12'h020] = 16'hB020;

    #2;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_kp_ack", kp_ack, 0);
    check("rst_seg", seg_data, 16'h0000);
    check("rst_m0_rdata", m0_rdata, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Tie from reset: m0 first, then strict alternation.
    set_m0(1, 0, 12'h010, 0);
    set_m1(1, 0, 12'h020, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tie_m0_gnt", m0_gnt, (i % 2) == 0);
      check("tie_m1_gnt", m1_gnt, (i % 2) == 1);
      tick();
      check("tie_m0_rvalid", m0_rvalid, (i % 2) == 0);
      check("tie_m1_rvalid", m1_rvalid, (i % 2) == 1);
      check("tie_rdata", (i % 2) ? m1_rdata : m0_rdata, (i % 2) ? 16'hB020 : 16'hA010);
      check("tie_loser_rdata", (i % 2) ? m0_rdata : m1_rdata, 16'h0000);
      if (i == 3) begin
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
      end
    end
    tick();
    check("idle_no_gnt", m0_gnt | m1_gnt, 0);

    // m0 memory read of 0x005.
    set_m0(1, 0, 12'h005, 0);
    tick();
    check("rd_gnt", m0_gnt, 1);
    check("rd_mem_addr", mem_addr, 12'h005);
    check("rd_mem_we", mem_we, 0);
    set_m0(0, 0, 0, 0);
    tick();
    check("rd_rvalid", m0_rvalid, 1);
    check("rd_rdata", m0_rdata, 16'h1234);
    check("rd_rerr", m0_rerr, 0);
    tick();

    // m0 memory write then read-back.
    set_m0(1, 1, 12'h033, 16'h5A5A);
    tick();
    check("mw_mem_we", mem_we, 1);
    check("mw_wdata", mem_wdata, 16'h5A5A);
    set_m0(1, 0, 12'h033, 0);
    tick();
    check("mw_rvalid", m0_rvalid, 1);
    tick();
    set_m0(0, 0, 0, 0);
    tick();
    check("mr_rdata", m0_rdata, 16'h5A5A);
    tick();

    // m1 writes the seven-segment register, then reads it back.
    set_m1(1, 1, 12'hB00, 16'hBEEF);
    tick();
    check("seg_gnt", m1_gnt, 1);
    check("seg_no_mem_we", mem_we, 0);
    set_m1(0, 0, 0, 0);
    tick();
    check("seg_data", seg_data, 16'hBEEF);
    check("seg_wr_rvalid", m1_rvalid, 1);
    check("seg_wr_rerr", m1_rerr, 0);
    set_m1(1, 0, 12'hB00, 0);
    tick();
    set_m1(0, 0, 0, 0);
    tick();
    check("seg_rd_rdata", m1_rdata, 16'hBEEF);
    tick();

    // Keypad data and status reads.
    kp_keyout = 16'h00A5;
    set_m0(1, 0, 12'h900, 0);
    tick();
    check("kp_ack_access", kp_ack, 1);
    check("kp_sod_data", kp_statusordata, 0);
    set_m0(1, 0, 12'h901, 0);
    tick();
    check("kp_ack_resp", kp_ack, 0);
    check("kp_data_rdata", m0_rdata, 16'h00A5);
    kp_keyout = 16'h0001;
    tick();
    check("kp_sod_access", kp_statusordata, 1);
    check("kp_stat_no_ack", kp_ack, 0);
    set_m0(1, 1, 12'h900, 16'h7777);
    tick();
    check("kp_stat_rdata", m0_rdata, 16'h0001);
    check("kp_sod_resp", kp_statusordata, 0);
    tick();
    check("kp_wr_no_ack", kp_ack, 0);
    set_m0(0, 0, 0, 0);
    tick();
    check("kp_wr_rerr", m0_rerr, 0);
    tick();

    // Unmapped read and write from m1.
    set_m1(1, 0, 12'h700, 0);
    tick();
    set_m1(1, 1, 12'h700, 16'h4444);
    tick();
    check("un_rd_rdata", m1_rdata, 16'hF345);
    check("un_rd_rerr", m1_rerr, 1);
    tick();
    check("un_wr_mem_we", mem_we, 0);
    set_m1(0, 0, 0, 0);
    tick();
    check("un_wr_rerr", m1_rerr, 1);
    check("un_wr_seg", seg_data, 16'hBEEF);
    tick();

    // Reset in the middle of a memory write ACCESS.
    set_m0(1, 1, 12'h040, 16'h5555);
    tick();
    check("rstw_mem_we_before", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_mem_we_drop", mem_we, 0);
    check("rstw_gnt_drop", m0_gnt, 0);
    check("rstw_seg_clear", seg_data, 16'h0000);
    set_m0(0, 0, 0, 0);
    tick();
    check("rstw_no_rvalid", m0_rvalid, 0);
    rst_n = 1'b1;
    tick();
    check("rstw_idle_no_gnt", m0_gnt | m1_gnt, 0);
    check("rstw_idle_no_rvalid", m0_rvalid | m1_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
